// File: rtl/ufp_mul_arbiter_if.sv
// Request/response bundle for the shared unsigned fixed-point multiplier.
// Requester i uses bit i of the per-requester vectors and lane [i*W +: W]
// of the packed operand buses. The master side is the requester pool and
// the slave side is the arbiter.
interface ufp_mul_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_clip;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           resp_clipping;
  logic           busy;
  logic [15:0]    op_count;

  modport master (
    output req_valid, req_x, req_y, req_clip,
    input  req_ready, resp_valid, resp_data, resp_clipping, busy, op_count
  );

  modport slave (
    input  req_valid, req_x, req_y, req_clip,
    output req_ready, resp_valid, resp_data, resp_clipping, busy, op_count
  );
endinterface

// File: rtl/ufp_mul_arbiter.sv
// Round-robin arbiter in front of one fully pipelined unsigned fixed-point
// multiplier. One operation is accepted per cycle at most. The result
// returns to the grantee exactly LAT cycles after it was accepted.
// Stage 0 registers the operands. The product is formed from stage 0, and
// LAT-1 further result registers delay it. When LAT is 1, the result is
// taken directly from the stage-0 product.
module ufp_mul_arbiter #(
  parameter int N   = 4,
  parameter int IW  = 16,
  parameter int QW  = 16,
  parameter int LAT = 2
) (
  input logic            clk,
  input logic            rst_n,
  ufp_mul_arbiter_if.slave bus
);
  localparam int W  = IW + QW;
  localparam int PW = 2 * W;
  localparam int TW = $clog2(N);

  // arbitration state and accept
  logic [TW-1:0] last_grant_reg;
  logic          grant_found;
  logic [TW-1:0] grant_idx;
  logic          accept;
  logic [15:0]   op_count_reg;
  logic [W-1:0]  sel_x;
  logic [W-1:0]  sel_y;
  logic          sel_clip;

  // stage 0: captured operands
  logic          s0_valid_reg;
  logic [W-1:0]  s0_x_reg;
  logic [W-1:0]  s0_y_reg;
  logic          s0_clip_reg;
  logic [TW-1:0] s0_tag_reg;

  // product and output stage
  logic [PW-1:0] mul_prod;
  logic          mul_ovf;
  logic [W-1:0]  mul_data;
  logic [QW-1:0] mul_lsb_unused;
  logic          out_valid;
  logic [TW-1:0] out_tag;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic          tail_busy;

  // Pick the first valid requester, searching from one past the last grantee
  always_comb begin : arb_comb
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (32'(last_grant_reg) + 32'(k)) % 32'(N);
      if (!grant_found && bus.req_valid[cand[TW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[TW-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held
  assign accept = rst_n & grant_found;

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign bus.req_ready[gi] = accept && (grant_idx == TW'(gi));
  end

  assign sel_x    = bus.req_x[grant_idx*W +: W];
  assign sel_y    = bus.req_y[grant_idx*W +: W];
  assign sel_clip = bus.req_clip[grant_idx];

  // Round-robin pointer and accept counter move only on an accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_reg <= TW'(N - 1);
      op_count_reg   <= '0;
    end else if (accept) begin
      last_grant_reg <= grant_idx;
      op_count_reg   <= op_count_reg + 16'd1;
    end
  end

  // Stage-0 valid bit; reset flushes in-flight work
  always_ff @(posedge clk) begin
    if (!rst_n) s0_valid_reg <= 1'b0;
    else        s0_valid_reg <= accept;
  end

  // Stage-0 payload is loaded only on an accept, so requesters may move on
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_x_reg    <= sel_x;
      s0_y_reg    <= sel_y;
      s0_clip_reg <= sel_clip;
      s0_tag_reg  <= grant_idx;
    end
  end

  // Full-width product; the fraction bits below QW are truncated
  assign mul_prod       = PW'(s0_x_reg) * PW'(s0_y_reg);
  assign mul_ovf        = |mul_prod[PW-1:W+QW];
  assign mul_data       = (mul_ovf && s0_clip_reg) ? '1 : mul_prod[W+QW-1:QW];
  assign mul_lsb_unused = mul_prod[QW-1:0];

  if (LAT == 1) begin : g_lat1
    assign out_valid = s0_valid_reg;
    assign out_tag   = s0_tag_reg;
    assign out_data  = mul_data;
    assign out_ovf   = mul_ovf;
    assign tail_busy = 1'b0;
  end else begin : g_latn
    localparam int D = LAT - 1;
    logic [D-1:0]  r_valid_reg;
    logic [D-1:0]  r_ovf_reg;
    logic [TW-1:0] r_tag_reg  [D];
    logic [W-1:0]  r_data_reg [D];

    // Result valid shift chain
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid_reg <= '0;
      end else begin
        r_valid_reg[0] <= s0_valid_reg;
        for (int k = 1; k < D; k++) r_valid_reg[k] <= r_valid_reg[k-1];
      end
    end

    // Result payload shift chain, which keeps the results in accept order
    always_ff @(posedge clk) begin
      r_tag_reg[0]  <= s0_tag_reg;
      r_data_reg[0] <= mul_data;
      r_ovf_reg[0]  <= mul_ovf;
      for (int k = 1; k < D; k++) begin
        r_tag_reg[k]  <= r_tag_reg[k-1];
        r_data_reg[k] <= r_data_reg[k-1];
        r_ovf_reg[k]  <= r_ovf_reg[k-1];
      end
    end

    assign out_valid = r_valid_reg[D-1];
    assign out_tag   = r_tag_reg[D-1];
    assign out_data  = r_data_reg[D-1];
    assign out_ovf   = r_ovf_reg[D-1];
    assign tail_busy = |r_valid_reg;
  end

  // Steer the result to its tag, and hold the data and flag at zero when idle or in reset
  always_comb begin
    bus.resp_valid    = '0;
    bus.resp_data     = '0;
    bus.resp_clipping = 1'b0;
    if (rst_n && out_valid) begin
      bus.resp_valid[out_tag] = 1'b1;
      bus.resp_data           = out_data;
      bus.resp_clipping       = out_ovf;
    end
  end

  assign bus.busy     = rst_n & (s0_valid_reg | tail_busy);
  assign bus.op_count = op_count_reg;
endmodule

// File: tb/tb_ufp_mul_arbiter.sv
// Directed bench for ufp_mul_arbiter (N=4, 16.16 operands, LAT=2).
// Inputs change just after the falling edge. Outputs are sampled 1 ns later.
module tb_ufp_mul_arbiter;
  localparam int N = 4, IW = 16, QW = 16, LAT = 2, W = IW + QW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ufp_mul_arbiter_if #(.N(N), .W(W)) bus ();

  ufp_mul_arbiter #(.N(N), .IW(IW), .QW(QW), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic clip);
    bus.req_x[i*W +: W] = x;
    bus.req_y[i*W +: W] = y;
    bus.req_clip[i]     = clip;
    $display("txn req%0d x=0x%08h y=0x%08h clip=%0d", i, x, y, clip);
  endtask

  logic [3:0] d_valid [6] = '{4'b0010, 4'b1010, 4'b1010, 4'b1110, 4'b1110, 4'b1110};
  logic [3:0] d_grant [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
  int granted = 0;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_clip = '0;

    // reset: no grants even with every request raised
    @(negedge clk); bus.req_valid = 4'hF; #1;
    check_eq("rst_ready", bus.req_ready, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    @(negedge clk); #1;
    check_eq("rst_op_count", bus.op_count, 0);
    check_eq("rst_resp_data", bus.resp_data, 0);
    check_eq("rst_resp_clip", bus.resp_clipping, 0);
    @(negedge clk); rst_n = 1'b1; bus.req_valid = '0; #1;
    check_eq("post_rst_resp_valid", bus.resp_valid, 0);
    check_eq("post_rst_busy", bus.busy, 0);

    // 2.0 * 3.5 = 7.0, no clipping, result on cycle T+2
    @(negedge clk); set_op(0, 32'h0002_0000, 32'h0003_8000, 1'b0); bus.req_valid = 4'b0001; #1;
    check_eq("a_ready", bus.req_ready, 4'b0001);
    @(negedge clk); bus.req_valid = '0; #1;
    check_eq("a_t1_resp_valid", bus.resp_valid, 0);
    check_eq("a_t1_busy", bus.busy, 1);
    @(negedge clk); #1;
    check_eq("a_resp_valid", bus.resp_valid, 4'b0001);
    check_eq("a_resp_data", bus.resp_data, 32'h0007_0000);
    check_eq("a_resp_clip", bus.resp_clipping, 0);
    check_eq("a_op_count", bus.op_count, 1);
    check_eq("a_t2_busy", bus.busy, 1);
    @(negedge clk); #1;
    check_eq("a_idle_valid", bus.resp_valid, 0);
    check_eq("a_idle_data", bus.resp_data, 0);
    check_eq("a_idle_busy", bus.busy, 0);

    // 256.0 * 256.0 overflows: saturate, then wrap, back to back
    @(negedge clk); set_op(0, 32'h0100_0000, 32'h0100_0000, 1'b1); bus.req_valid = 4'b0001; #1;
    check_eq("b_ready_sat", bus.req_ready, 4'b0001);
    @(negedge clk); set_op(0, 32'h0100_0000, 32'h0100_0000, 1'b0); #1;
    check_eq("b_ready_wrap", bus.req_ready, 4'b0001);
    @(negedge clk); bus.req_valid = '0; #1;
    check_eq("b_sat_valid", bus.resp_valid, 4'b0001);
    check_eq("b_sat_data", bus.resp_data, 32'hFFFF_FFFF);
    check_eq("b_sat_clip", bus.resp_clipping, 1);
    @(negedge clk); #1;
    check_eq("b_wrap_valid", bus.resp_valid, 4'b0001);
    check_eq("b_wrap_data", bus.resp_data, 32'h0000_0000);
    check_eq("b_wrap_clip", bus.resp_clipping, 1);

    // full round robin from a fresh reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("c_op_count_reset", bus.op_count, 0);
    for (int i = 0; i < N; i++) set_op(i, 32'((i + 1) << 16), 32'h0001_0000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) check_eq($sformatf("c_grant%0d", k), bus.req_ready, 64'(1) << (k % 4));
      if (k >= 2) begin
        check_eq($sformatf("c_resp_valid%0d", k), bus.resp_valid, 64'(1) << ((k - 2) % 4));
        check_eq($sformatf("c_resp_data%0d", k), bus.resp_data, 64'((k - 2) % 4 + 1) << 16);
      end
    end
    check_eq("c_op_count", bus.op_count, 8);

    // rotation after partial request sets (last grant was 3)
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); bus.req_valid = d_valid[k]; #1;
      check_eq($sformatf("d_grant%0d", k), bus.req_ready, d_grant[k]);
    end
    @(negedge clk); bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("d_op_count", bus.op_count, 14);
    check_eq("d_idle_busy", bus.busy, 0);

    // reset with two ops in flight discards both
    @(negedge clk); bus.req_valid = 4'b0001; #1;
    check_eq("e_ready0", bus.req_ready, 4'b0001);
    @(negedge clk); #1;
    check_eq("e_ready1", bus.req_ready, 4'b0001);
    @(negedge clk); rst_n = 1'b0; bus.req_valid = 4'hF; #1;
    check_eq("e_rst_resp_valid", bus.resp_valid, 0);
    check_eq("e_rst_ready", bus.req_ready, 0);
    check_eq("e_rst_busy", bus.busy, 0);
    @(negedge clk); rst_n = 1'b1; bus.req_valid = '0; #1;
    check_eq("e_post_resp_valid", bus.resp_valid, 0);
    check_eq("e_post_busy", bus.busy, 0);
    check_eq("e_post_op_count", bus.op_count, 0);
    @(negedge clk); bus.req_valid = 4'hF; #1;
    check_eq("e_first_grant", bus.req_ready, 4'b0001);
    check_eq("e_late_resp_valid", bus.resp_valid, 0);

    // op_count wrap with one persistent requester
    @(negedge clk); rst_n = 1'b0; bus.req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); set_op(0, 32'h0, 32'h0, 1'b0); bus.req_valid = 4'b0001;
    for (int k = 0; k < 65535; k++) begin
      #1;
      if (bus.req_ready == 4'b0001) granted++;
      @(negedge clk);
    end
    set_op(0, 32'h0000_0001, 32'h0000_0001, 1'b0); #1;
    check_eq("f_granted_every_cycle", granted, 65535);
    check_eq("f_op_count_max", bus.op_count, 16'hFFFF);
    check_eq("f_last_ready", bus.req_ready, 4'b0001);
    @(negedge clk); bus.req_valid = '0; #1;
    check_eq("f_op_count_wrap", bus.op_count, 0);
    @(negedge clk); #1;
    check_eq("f_tiny_valid", bus.resp_valid, 4'b0001);
    check_eq("f_tiny_data", bus.resp_data, 0);
    check_eq("f_tiny_clip", bus.resp_clipping, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/ufp_mul_arbiter.md
UFP_MUL_ARBITER -- requirements
Module: ufp_mul_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 Parameter IW, default 16, integer bits of unsigned fixed-point operands.
REQ-003 Parameter QW, default 16, fractional bits; operand/result width W = IW+QW.
REQ-004 Parameter LAT, default 2, accept-to-response latency in cycles (1..4).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-007 req_valid  input  N  requester i presents an operation.
REQ-008 req_ready  output  N  grant to requester i; combinational, one-hot or zero.
REQ-009 req_x  input  N*W  operand x, requester i in bits [i*W +: W].
REQ-010 req_y  input  N*W  operand y, same packing.
REQ-011 req_clip  input  N  1 = saturate on overflow, 0 = wrap.
REQ-012 resp_valid  output  N  registered one-cycle result strobe for requester i; no backpressure.
REQ-013 resp_data  output  W  result, valid when any resp_valid bit is set.
REQ-014 resp_clipping  output  1  overflow flag accompanying resp_data.
REQ-015 busy  output  1  high while any accepted operation is in flight.
REQ-016 op_count  output  16  count of accepted operations, wraps at 2^16.

Function
REQ-017 Accept on requester i = req_valid[i] & req_ready[i]; at most one accept per cycle.
REQ-018 req_ready[i] high only when req_valid[i] high and i wins arbitration; no dependence on resp path.
REQ-019 Round-robin: search starts at (last_grant+1) mod N, first valid wins; last_grant updates only on accept.
REQ-020 After reset last_grant = N-1, so requester 0 has top priority first.
REQ-021 Operand, clip and tag (grantee index) captured on accept; requester may change inputs next cycle.
REQ-022 Product P = x*y, full 2W bits, unsigned, no rounding (truncation).
REQ-023 Overflow = OR of P[2W-1 : W+QW]; unrounded result R = P[W+QW-1 : QW].
REQ-024 resp_data = all-ones if overflow & clip, else R (wrap); resp_clipping = overflow in both modes.
REQ-025 Operation accepted at cycle T produces resp_valid[tag] high exactly at cycle T+LAT, for one cycle.
REQ-026 Pipeline fully pipelined: new accept allowed every cycle; results return in accept order.
REQ-027 resp_data and resp_clipping are 0 in any cycle with resp_valid == 0.
REQ-028 busy = OR of valid bits across LAT pipeline stages (not including current-cycle accept).
REQ-029 op_count increments by 1 per accept; 16'hFFFF + 1 -> 16'h0000.
REQ-030 No valid requests: no accept, last_grant held, pipeline drains normally.
REQ-031 Single persistent requester is granted every cycle (no forced idle).

Reset
REQ-032 rst_n low at a rising edge: all pipeline valid bits cleared, last_grant = N-1, op_count = 0.
REQ-033 During and one cycle after reset: resp_valid = 0, resp_data = 0, resp_clipping = 0, busy = 0.
REQ-034 req_ready = 0 for all i while rst_n low.
REQ-035 Reset mid-operation discards in-flight work; no resp_valid ever issued for ops accepted before reset.

Verification
REQ-036 Req 0 only, x=0x0002_0000, y=0x0003_8000, clip=0 -> ready[0] same cycle, resp_valid[0] at T+2, resp_data=0x0007_0000, clipping=0.
REQ-037 x=0x0100_0000, y=0x0100_0000: clip=1 -> resp_data=0xFFFF_FFFF, clipping=1; clip=0 -> resp_data=0x0000_0000, clipping=1.
REQ-038 All 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one resp_valid per cycle from T+2, tags in same order; op_count=8.
REQ-039 Req 1 and 3 valid after last grant was 1 -> grant 3 then 1; req 2 joining wins before 1.
REQ-040 Accept ops in two consecutive cycles, assert rst_n=0 next cycle -> no resp_valid afterwards, busy=0, op_count=0, next grant goes to requester 0.
REQ-041 Preload op_count 65535 accepts, one more -> op_count=0; x=0x0000_0001, y=0x0000_0001 -> resp_data=0 (truncated), clipping=0.
